// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 key decoder.
//   - Set-2 scan constants (prefixes, modifier keys, controller status codes)
//   - decoder FSM state enum
//   - event-word bit positions
//   - helper that flags controller status bytes that carry no key information
package ps2_pkg;

    localparam logic [7:0] SC_E0       = 8'hE0;
    localparam logic [7:0] SC_F0       = 8'hF0;
    localparam logic [7:0] SC_LSHIFT   = 8'h12;
    localparam logic [7:0] SC_RSHIFT   = 8'h59;
    localparam logic [7:0] SC_CTRL     = 8'h14;
    localparam logic [7:0] SC_ALT      = 8'h11;
    localparam logic [7:0] SC_CAPS     = 8'h58;
    localparam logic [7:0] SC_BAT_OK   = 8'hAA;
    localparam logic [7:0] SC_ACK      = 8'hFA;
    localparam logic [7:0] SC_RESEND   = 8'hFE;
    localparam logic [7:0] SC_ERR_00   = 8'h00;
    localparam logic [7:0] SC_ERR_FF   = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_t;

    localparam int EV_VALID = 15;
    localparam int EV_OVF   = 14;
    localparam int EV_BRK   = 13;
    localparam int EV_EXT   = 12;
    localparam int EV_SHIFT = 11;
    localparam int EV_CTRL  = 10;
    localparam int EV_ALT   = 9;
    localparam int EV_CAPS  = 8;

    function automatic logic is_status_code(input logic [7:0] b);
        return (b == SC_BAT_OK) || (b == SC_ACK) || (b == SC_RESEND) ||
               (b == SC_ERR_00) || (b == SC_ERR_FF);
    endfunction

endpackage

// File: rtl/ps2_set2_ascii.sv
// ps2_set2_ascii: combinational Set-2 scan code to ASCII table.
// Ports:
//   i_scan  [7:0]  non-extended scan byte
//   i_shift        shift held
//   i_caps         caps lock active
//   o_ascii [7:0]  translated character, 00 when the code has no mapping
// Letters use shift XOR caps; every other mapped key uses shift alone.
module ps2_set2_ascii (
    input  logic [7:0] i_scan,
    input  logic       i_shift,
    input  logic       i_caps,
    output logic [7:0] o_ascii
);

    logic [7:0] w_lo;
    logic [7:0] w_hi;
    logic       w_letter;
    logic       w_use_hi;

    always_comb begin
        w_lo     = 8'h00;
        w_hi     = 8'h00;
        w_letter = 1'b0;
        case (i_scan)
            8'h1C: begin w_lo = 8'h61; w_letter = 1'b1; end // a
            8'h32: begin w_lo = 8'h62; w_letter = 1'b1; end
            8'h21: begin w_lo = 8'h63; w_letter = 1'b1; end
            8'h23: begin w_lo = 8'h64; w_letter = 1'b1; end
            8'h24: begin w_lo = 8'h65; w_letter = 1'b1; end
            8'h2B: begin w_lo = 8'h66; w_letter = 1'b1; end
            8'h34: begin w_lo = 8'h67; w_letter = 1'b1; end
            8'h33: begin w_lo = 8'h68; w_letter = 1'b1; end
            8'h43: begin w_lo = 8'h69; w_letter = 1'b1; end
            8'h3B: begin w_lo = 8'h6A; w_letter = 1'b1; end
            8'h42: begin w_lo = 8'h6B; w_letter = 1'b1; end
            8'h4B: begin w_lo = 8'h6C; w_letter = 1'b1; end
            8'h3A: begin w_lo = 8'h6D; w_letter = 1'b1; end
            8'h31: begin w_lo = 8'h6E; w_letter = 1'b1; end
            8'h44: begin w_lo = 8'h6F; w_letter = 1'b1; end
            8'h4D: begin w_lo = 8'h70; w_letter = 1'b1; end
            8'h15: begin w_lo = 8'h71; w_letter = 1'b1; end
            8'h2D: begin w_lo = 8'h72; w_letter = 1'b1; end
            8'h1B: begin w_lo = 8'h73; w_letter = 1'b1; end
            8'h2C: begin w_lo = 8'h74; w_letter = 1'b1; end
            8'h3C: begin w_lo = 8'h75; w_letter = 1'b1; end
            8'h2A: begin w_lo = 8'h76; w_letter = 1'b1; end
            8'h1D: begin w_lo = 8'h77; w_letter = 1'b1; end
            8'h22: begin w_lo = 8'h78; w_letter = 1'b1; end
            8'h35: begin w_lo = 8'h79; w_letter = 1'b1; end
            8'h1A: begin w_lo = 8'h7A; w_letter = 1'b1; end
            8'h16: begin w_lo = 8'h31; w_hi = 8'h21; end // 1 !
            8'h1E: begin w_lo = 8'h32; w_hi = 8'h40; end
            8'h26: begin w_lo = 8'h33; w_hi = 8'h23; end
            8'h25: begin w_lo = 8'h34; w_hi = 8'h24; end
            8'h2E: begin w_lo = 8'h35; w_hi = 8'h25; end
            8'h36: begin w_lo = 8'h36; w_hi = 8'h5E; end
            8'h3D: begin w_lo = 8'h37; w_hi = 8'h26; end
            8'h3E: begin w_lo = 8'h38; w_hi = 8'h2A; end
            8'h46: begin w_lo = 8'h39; w_hi = 8'h28; end
            8'h45: begin w_lo = 8'h30; w_hi = 8'h29; end
            8'h4E: begin w_lo = 8'h2D; w_hi = 8'h5F; end
            8'h55: begin w_lo = 8'h3D; w_hi = 8'h2B; end
            8'h54: begin w_lo = 8'h5B; w_hi = 8'h7B; end
            8'h5B: begin w_lo = 8'h5D; w_hi = 8'h7D; end
            8'h5D: begin w_lo = 8'h5C; w_hi = 8'h7C; end
            8'h4C: begin w_lo = 8'h3B; w_hi = 8'h3A; end
            8'h52: begin w_lo = 8'h27; w_hi = 8'h22; end
            8'h41: begin w_lo = 8'h2C; w_hi = 8'h3C; end
            8'h49: begin w_lo = 8'h2E; w_hi = 8'h3E; end
            8'h4A: begin w_lo = 8'h2F; w_hi = 8'h3F; end
            8'h0E: begin w_lo = 8'h60; w_hi = 8'h7E; end
            8'h29: begin w_lo = 8'h20; w_hi = 8'h20; end // space
            8'h5A: begin w_lo = 8'h0D; w_hi = 8'h0D; end // enter
            8'h66: begin w_lo = 8'h08; w_hi = 8'h08; end // backspace
            8'h0D: begin w_lo = 8'h09; w_hi = 8'h09; end // tab
            8'h76: begin w_lo = 8'h1B; w_hi = 8'h1B; end // escape
            default: begin w_lo = 8'h00; w_hi = 8'h00; end
        endcase
    end

    assign w_use_hi = w_letter ? (i_shift ^ i_caps) : i_shift;
    // Upper-case letters differ from lower-case only in bit 5.
    assign o_ascii  = w_use_hi ? (w_letter ? (w_lo & 8'hDF) : w_hi) : w_lo;

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns PS/2 Set-2 scan bytes into queued key events.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_kb_word [8:0]   receiver word: [8] valid, [7:0] scan byte
//   i_sel, i_rd       bus select and read strobe; sel&rd pops the head entry
//   o_rdata [15:0]    head event: [15] valid [14] overflow [13] break
//                     [12] extended [11:8] shift/ctrl/alt/caps [7:0] ascii|scan
//   o_irq             FIFO non-empty
//   o_dbg_state [1:0] decoder FSM state
// Pipeline: byte detect -> event register -> write stage -> FIFO/rdata.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int EMIT_BREAK = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  i_kb_word,
    input  logic        i_sel,
    input  logic        i_rd,
    output logic [15:0] o_rdata,
    output logic        o_irq,
    output logic [1:0]  o_dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL = DEPTH[AW:0];

    ps2_state_t  r_state;
    logic [7:0]  r_last;
    logic        r_seen;
    logic        r_shift_l, r_shift_r, r_ctrl, r_alt, r_caps;
    logic        r_ev_valid;
    logic [13:0] r_ev_word;
    logic        r_wr_valid;
    logic [13:0] r_wr_word;
    logic [13:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0] r_count;
    logic        r_ovf;

    logic [7:0]  w_byte;
    logic        w_new, w_key, w_brk, w_ext, w_shift;
    logic        w_is_lsh, w_is_rsh, w_is_ctrl, w_is_alt, w_is_caps, w_is_mod;
    logic [7:0]  w_ascii;
    logic [13:0] w_ev;
    logic        w_pop, w_push, w_full;

    assign w_byte = i_kb_word[7:0];
    // Identical consecutive bytes collapse, so typematic repeats are dropped.
    assign w_new  = i_kb_word[8] && (!r_seen || (w_byte != r_last));
    assign w_brk  = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);
    assign w_ext  = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
    assign w_shift = r_shift_l | r_shift_r;

    // w_key: this byte completes a key code (make or break).
    always_comb begin
        w_key = 1'b0;
        case (r_state)
            ST_IDLE: w_key = w_new && (w_byte != SC_E0) && (w_byte != SC_F0) &&
                             !is_status_code(w_byte);
            ST_EXT:  w_key = w_new && (w_byte != SC_F0);
            default: w_key = w_new;
        endcase
    end

    // Ctrl and Alt exist on both sides (E0 prefix = right key); shift and
    // caps have no extended twin.
    assign w_is_lsh  = !w_ext && (w_byte == SC_LSHIFT);
    assign w_is_rsh  = !w_ext && (w_byte == SC_RSHIFT);
    assign w_is_caps = !w_ext && (w_byte == SC_CAPS);
    assign w_is_ctrl = (w_byte == SC_CTRL);
    assign w_is_alt  = (w_byte == SC_ALT);
    assign w_is_mod  = w_is_lsh | w_is_rsh | w_is_caps | w_is_ctrl | w_is_alt;

    ps2_set2_ascii u_rom (
        .i_scan  (w_byte),
        .i_shift (w_shift),
        .i_caps  (r_caps),
        .o_ascii (w_ascii)
    );

    always_comb begin
        w_ev           = '0;
        w_ev[EV_BRK]   = w_brk;
        w_ev[EV_EXT]   = w_ext;
        w_ev[EV_SHIFT] = w_shift;
        w_ev[EV_CTRL]  = r_ctrl;
        w_ev[EV_ALT]   = r_alt;
        w_ev[EV_CAPS]  = r_caps;
        w_ev[7:0]      = (w_ext || (w_ascii == 8'h00)) ? w_byte : w_ascii;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_last     <= 8'h00;
            r_seen     <= 1'b0;
            r_shift_l  <= 1'b0;
            r_shift_r  <= 1'b0;
            r_ctrl     <= 1'b0;
            r_alt      <= 1'b0;
            r_caps     <= 1'b0;
            r_ev_valid <= 1'b0;
            r_ev_word  <= '0;
        end else begin
            r_ev_valid <= 1'b0;
            if (w_new) begin
                r_last <= w_byte;
                r_seen <= 1'b1;
                case (r_state)
                    ST_IDLE: begin
                        if (w_byte == SC_E0)      r_state <= ST_EXT;
                        else if (w_byte == SC_F0) r_state <= ST_BRK;
                    end
                    ST_EXT:  r_state <= (w_byte == SC_F0) ? ST_EXT_BRK : ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
                if (w_key) begin
                    if (w_is_lsh)  r_shift_l <= !w_brk;
                    if (w_is_rsh)  r_shift_r <= !w_brk;
                    if (w_is_ctrl) r_ctrl    <= !w_brk;
                    if (w_is_alt)  r_alt     <= !w_brk;
                    if (w_is_caps && !w_brk) r_caps <= !r_caps;
                    r_ev_valid <= !w_is_mod && (!w_brk || (EMIT_BREAK != 0));
                    r_ev_word  <= w_ev;
                end
            end
        end
    end

    assign w_full = (r_count == C_FULL);
    assign w_pop  = i_sel && i_rd && (r_count != '0);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push = r_wr_valid && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_valid <= 1'b0;
            r_wr_word  <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_wr_valid <= r_ev_valid;
            r_wr_word  <= r_ev_word;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
            if (w_pop)
                r_ovf <= 1'b0;
            else if (r_wr_valid && w_full)
                r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= r_wr_word;
    end

    assign o_irq       = (r_count != '0);
    assign o_rdata     = o_irq ? {1'b1, r_ovf, r_mem[r_rptr]} : {1'b0, r_ovf, 14'd0};
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

    logic        clk;
    logic        rst;
    logic [8:0]  kb_word;
    logic        mon_sel, mon_rd, man_sel, man_rd;
    logic        w_sel, w_rd;
    logic [15:0] o_rdata;
    logic        o_irq;
    logic [1:0]  o_dbg_state;
    logic        b_sel, b_rd;
    logic [15:0] b_rdata;
    logic        b_irq;
    logic [1:0]  b_dbg_state;

    logic [15:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic        auto_read = 1'b0;

    assign w_sel = mon_sel | man_sel;
    assign w_rd  = mon_rd  | man_rd;

    ps2_key_decoder #(.DEPTH(8), .EMIT_BREAK(0)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .i_kb_word   (kb_word),
        .i_sel       (w_sel),
        .i_rd        (w_rd),
        .o_rdata     (o_rdata),
        .o_irq       (o_irq),
        .o_dbg_state (o_dbg_state)
    );

    ps2_key_decoder #(.DEPTH(8), .EMIT_BREAK(1)) u_dut_brk (
        .clk         (clk),
        .rst         (rst),
        .i_kb_word   (kb_word),
        .i_sel       (b_sel),
        .i_rd        (b_rd),
        .o_rdata     (b_rdata),
        .o_irq       (b_irq),
        .o_dbg_state (b_dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Present one byte for exactly one cycle; entered and left at a negedge.
    task automatic send(input logic [7:0] b);
        kb_word = {1'b1, b};
        @(negedge clk);
        kb_word = '0;
    endtask

    task automatic pulse_brk_read();
        b_sel = 1'b1;
        b_rd  = 1'b1;
        @(negedge clk);
        b_sel = 1'b0;
        b_rd  = 1'b0;
    endtask

    // Let the pipeline settle, then wait (bounded) for the monitor to empty the FIFO.
    task automatic drain(input string name);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 200 && (exp_q.size() != 0 || o_irq); i++) @(negedge clk);
        check({name, "_exp_left"}, 16'(exp_q.size()), 16'd0);
        check({name, "_irq_low"}, {15'd0, o_irq}, 16'd0);
        check({name, "_rdata_zero"}, o_rdata, 16'h0000);
    endtask

    // Scoreboard monitor: pop-and-compare whenever the DUT shows a valid head.
    initial begin
        mon_sel = 1'b0;
        mon_rd  = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_read && o_rdata[15]) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_event actual=%h required=none", o_rdata);
                end else begin
                    check("event", o_rdata, exp_q.pop_front());
                end
                mon_sel = 1'b1;
                mon_rd  = 1'b1;
                @(negedge clk);
                mon_sel = 1'b0;
                mon_rd  = 1'b0;
            end
        end
    end

    initial begin
        rst     = 1'b1;
        kb_word = '0;
        man_sel = 1'b0;
        man_rd  = 1'b0;
        b_sel   = 1'b0;
        b_rd    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_rdata", o_rdata, 16'h0000);
        check("reset_irq", {15'd0, o_irq}, 16'd0);
        check("reset_state", {14'd0, o_dbg_state}, 16'd0);
        check("reset_rdata_brk", b_rdata, 16'h0000);

        // Latency: 'a' appears three cycles after the byte.
        send(8'h1C);
        @(negedge clk);
        check("lat_n2_empty", o_rdata, 16'h0000);
        @(negedge clk);
        check("lat_n3_head", o_rdata, 16'h8061);
        check("lat_n3_irq", {15'd0, o_irq}, 16'd1);
        exp_q.push_back(16'h8061);
        auto_read = 1'b1;
        drain("t1");

        // Shift held around 'A'; a plain 'a' afterwards proves shift released.
        exp_q.push_back(16'h8841);
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
        exp_q.push_back(16'h8061);
        send(8'h1C); send(8'hF0); send(8'h1C);
        drain("t2");

        // Caps lock, shift with caps, ignored status bytes, punctuation, ctrl, alt.
        exp_q.push_back(16'h8151);
        send(8'h58); send(8'hF0); send(8'h58); send(8'h15);
        exp_q.push_back(16'h8971);
        send(8'hF0); send(8'h15); send(8'h12); send(8'h15);
        exp_q.push_back(16'h8061);
        send(8'hF0); send(8'h15); send(8'hF0); send(8'h12);
        send(8'h58); send(8'hF0); send(8'h58); send(8'hAA); send(8'hFA); send(8'h1C);
        exp_q.push_back(16'h8821);
        send(8'hF0); send(8'h1C); send(8'h12); send(8'h16);
        exp_q.push_back(16'h8463);
        send(8'hF0); send(8'h16); send(8'hF0); send(8'h12); send(8'h14); send(8'h21);
        exp_q.push_back(16'h8661);
        send(8'hE0); send(8'h11); send(8'h1C);
        exp_q.push_back(16'h8066);
        send(8'hF0); send(8'h1C); send(8'hE0); send(8'hF0); send(8'h11);
        send(8'hF0); send(8'h14); send(8'h2B);
        drain("t3");

        // Extended make on both instances, extended break only with EMIT_BREAK=1.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(16'h9075);
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        repeat (4) @(negedge clk);
        check("brk_head_make", b_rdata, 16'h9075);
        pulse_brk_read();
        check("brk_head_break", b_rdata, 16'hB075);
        pulse_brk_read();
        check("brk_empty", b_rdata, 16'h0000);
        check("brk_irq_low", {15'd0, b_irq}, 16'd0);
        drain("t4");

        // Reset between E0 and 75: the 75 is a fresh, non-extended make.
        send(8'hE0);
        check("prefix_state_ext", {14'd0, o_dbg_state}, 16'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("prefix_state_idle", {14'd0, o_dbg_state}, 16'd0);
        exp_q.push_back(16'h8075);
        send(8'h75);
        drain("t5");

        // Overflow: nine makes without reads, then push and pop together while full.
        auto_read = 1'b0;
        send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
        send(8'h2B); send(8'h34); send(8'h33); send(8'h43);
        repeat (4) @(negedge clk);
        check("ovf_head", o_rdata, 16'hC061);
        check("ovf_irq", {15'd0, o_irq}, 16'd1);
        send(8'h42);
        @(negedge clk);
        man_sel = 1'b1;
        man_rd  = 1'b1;
        @(negedge clk);
        man_sel = 1'b0;
        man_rd  = 1'b0;
        check("full_push_pop_head", o_rdata, 16'h8062);
        exp_q.push_back(16'h8062); exp_q.push_back(16'h8063);
        exp_q.push_back(16'h8064); exp_q.push_back(16'h8065);
        exp_q.push_back(16'h8066); exp_q.push_back(16'h8067);
        exp_q.push_back(16'h8068); exp_q.push_back(16'h806B);
        auto_read = 1'b1;
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
